// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the odd-parity helper used when building a host-to-device packet.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Host-side request/status bundle of the PS/2 transmitter.
interface ps2_tx_if;

    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (
        output wr_ps2,
        output din,
        input  tx_idle,
        input  tx_done_tick,
        input  tx_err
    );

    modport slave (
        input  wr_ps2,
        input  din,
        output tx_idle,
        output tx_done_tick,
        output tx_err
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock line plus falling-edge detect on the
// filtered value; shared by the PS/2 receive and transmit paths.
module ps2_clk_filter (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic f_ps2c,
    output logic fall_edge
);

    logic [7:0] filter_reg;
    logic       f_next;

    // Only a full run of identical samples changes the filtered level.
    always_comb begin
        f_next = f_ps2c;
        if (filter_reg == '1)
            f_next = 1'b1;
        else if (filter_reg == '0)
            f_next = 1'b0;
    end

    assign fall_edge = f_ps2c & ~f_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            filter_reg <= '0;
            f_ps2c     <= 1'b0;
        end else begin
            filter_reg <= {ps2c, filter_reg[7:1]};
            f_ps2c     <= f_next;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 11-bit
// frame clocked by the device, ACK capture and inter-edge timeout abort.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    ps2_tx_if.slave    bus,
    inout  wire        ps2c,
    inout  wire        ps2d
);

    localparam int unsigned MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CYC) + 1;
    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t    state;
    logic [8:0]    packet;
    logic [3:0]    n;
    logic [TW-1:0] timer;
    logic          nack;
    logic          c_drive;
    logic          d_drive;
    logic          f_ps2c;
    logic          fall_edge;
    logic [1:0]    d_sync;

    ps2_clk_filter u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .f_ps2c    (f_ps2c),
        .fall_edge (fall_edge)
    );

    // Open-drain: only ever pull low, otherwise release.
    assign ps2c = c_drive ? 1'b0 : 1'bz;
    assign ps2d = d_drive ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset)
            d_sync <= '1;
        else
            d_sync <= {d_sync[0], ps2d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            packet           <= '0;
            n                <= '0;
            timer            <= '0;
            nack             <= 1'b0;
            c_drive          <= 1'b0;
            d_drive          <= 1'b0;
            bus.tx_idle      <= 1'b1;
            bus.tx_done_tick <= 1'b0;
            bus.tx_err       <= 1'b0;
        end else begin
            bus.tx_done_tick <= 1'b0;
            bus.tx_err       <= 1'b0;
            bus.tx_idle      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    c_drive     <= 1'b0;
                    d_drive     <= 1'b0;
                    bus.tx_idle <= ~bus.wr_ps2;
                    if (bus.wr_ps2) begin
                        packet  <= {odd_parity(bus.din), bus.din};
                        timer   <= INH_LOAD;
                        c_drive <= 1'b1;
                        state   <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (timer == '0) begin
                        c_drive <= 1'b0;
                        d_drive <= 1'b1;
                        timer   <= TO_LOAD;
                        state   <= ST_START;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    // Device-clocked phases share one watchdog, rearmed per edge.
                    if (!fall_edge && timer == '0) begin
                        c_drive          <= 1'b0;
                        d_drive          <= 1'b0;
                        bus.tx_done_tick <= 1'b1;
                        bus.tx_err       <= 1'b1;
                        state            <= ST_IDLE;
                    end else begin
                        timer <= fall_edge ? TO_LOAD : timer - 1'b1;
                        case (state)
                            ST_START: begin
                                if (fall_edge) begin
                                    n       <= '0;
                                    d_drive <= ~packet[0];
                                    state   <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (fall_edge) begin
                                    if (n == 4'd8) begin
                                        d_drive <= 1'b0;
                                        state   <= ST_STOP;
                                    end else begin
                                        n       <= n + 4'd1;
                                        d_drive <= ~packet[n + 4'd1];
                                    end
                                end
                            end
                            ST_STOP: begin
                                if (fall_edge) begin
                                    nack  <= d_sync[1];
                                    state <= ST_WAIT;
                                end
                            end
                            ST_WAIT: begin
                                if (f_ps2c && d_sync[1]) begin
                                    bus.tx_done_tick <= 1'b1;
                                    bus.tx_err       <= nack;
                                    state            <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device on pulled-up lines.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 20;
    localparam int unsigned TO  = 500;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;
    wire  ps2c;
    wire  ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_tx_if bus ();

    ps2_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .ps2c  (ps2c),
        .ps2d  (ps2d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(posedge clk) if (bus.tx_done_tick === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.din    = b;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
    endtask

    // Entered in the cycle after acceptance; leaves at the first released cycle.
    task automatic check_inhibit(input string tag);
        int n = 0;
        while (ps2c === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_inhibit_len"}, n, INH);
    endtask

    task automatic frame(input int stop_after, input logic nack, input int inject_at,
                         input int reset_at, output logic [10:0] s);
        s    = 'x;
        s[0] = ps2d;
        repeat (30) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k > stop_after) break;
            if (k == inject_at) begin
                bus.din    = 8'h55;
                bus.wr_ps2 = 1'b1;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
                chk("inject_busy", bus.tx_idle, 1'b0);
            end
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_mid_ps2c", ps2c, 1'b1);
                chk("rst_mid_ps2d", ps2d, 1'b1);
                chk("rst_mid_idle", bus.tx_idle, 1'b1);
                chk("rst_mid_done", bus.tx_done_tick, 1'b0);
                reset = 1'b0;
                break;
            end
            if (k == 11) dev_d = ~nack;
            dev_c = 1'b1;
            repeat (20) @(negedge clk);
            if (k <= 10) s[k] = ps2d;
            dev_c = 1'b0;
            if (k == 11) dev_d = 1'b0;
            else repeat (20) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input int bound,
                             input logic b2b, input logic [7:0] b2b_byte, output int n);
        n = 0;
        while (bus.tx_done_tick !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, bus.tx_done_tick, 1'b1);
        chk({tag, "_err"}, bus.tx_err, exp_err);
        chk({tag, "_idle_in_pulse"}, bus.tx_idle, 1'b0);
        chk({tag, "_ps2d_released"}, ps2d, 1'b1);
        if (b2b) begin
            bus.din    = b2b_byte;
            bus.wr_ps2 = 1'b1;
            @(negedge clk);
            bus.wr_ps2 = 1'b0;
        end else begin
            @(negedge clk);
            chk({tag, "_idle_after"}, bus.tx_idle, 1'b1);
            chk({tag, "_done_one_cycle"}, bus.tx_done_tick, 1'b0);
        end
    endtask

    initial begin
        logic [10:0] s;
        int          n;
        int          saved;

        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;

        // Request held during reset must be ignored.
        repeat (2) @(negedge clk);
        bus.din    = CMD_SET_LED;
        bus.wr_ps2 = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr_ps2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle", bus.tx_idle, 1'b1);
        chk("rst_done", bus.tx_done_tick, 1'b0);
        chk("rst_err", bus.tx_err, 1'b0);
        chk("rst_ps2c", ps2c, 1'b1);
        chk("rst_ps2d", ps2d, 1'b1);
        repeat (20) @(negedge clk);
        chk("rst_wr_ignored", ps2c, 1'b1);

        // 8'hED with ACK, then 8'h00 issued back-to-back in the done cycle.
        send(CMD_SET_LED);
        check_inhibit("ed");
        frame(11, 1'b0, 0, 0, s);
        chk("ed_frame", {21'd0, s}, 32'h7DA);
        wait_done("ed", 1'b0, 100, 1'b1, 8'h00, n);
        check_inhibit("b2b00");
        frame(11, 1'b0, 0, 0, s);
        chk("b2b00_frame", {21'd0, s}, 32'h600);
        wait_done("b2b00", 1'b0, 100, 1'b0, 8'h00, n);

        // 8'h01 (parity 0) with device NACK.
        send(8'h01);
        check_inhibit("nack01");
        frame(11, 1'b1, 0, 0, s);
        chk("nack01_frame", {21'd0, s}, 32'h402);
        wait_done("nack01", 1'b1, 100, 1'b0, 8'h00, n);

        // Device stops clocking after edge 4.
        send(8'h00);
        check_inhibit("tmo");
        frame(4, 1'b0, 0, 0, s);
        wait_done("tmo", 1'b1, 700, 1'b0, 8'h00, n);
        chk("tmo_window", {31'd0, (n + 40 >= 500) && (n + 40 <= 515)}, 32'd1);
        chk("tmo_ps2c_released", ps2c, 1'b1);

        // Second request during DATA is ignored.
        send(CMD_SET_LED);
        check_inhibit("inj");
        frame(11, 1'b0, 5, 0, s);
        chk("inj_frame", {21'd0, s}, 32'h7DA);
        wait_done("inj", 1'b0, 100, 1'b0, 8'h00, n);

        // Reset during DATA aborts silently.
        send(8'h00);
        check_inhibit("rstd");
        frame(11, 1'b0, 0, 4, s);
        saved = done_cnt;
        repeat (50) @(negedge clk);
        chk("rstd_no_done", done_cnt, saved);
        chk("rstd_idle", bus.tx_idle, 1'b1);

        // Recovery after reset.
        send(CMD_RESET);
        check_inhibit("ff");
        frame(11, 1'b0, 0, 0, s);
        chk("ff_frame", {21'd0, s}, 32'h7FE);
        wait_done("ff", 1'b0, 100, 1'b0, 8'h00, n);

        chk("done_total", done_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
